rtc_bus_responder: RTL
======================

Name: rtc_bus_responder

Overview:
- Synthesizable responder for the multiplexed address/data RTC bus: cs_n, rd_n, wr_n, a_d, 8-bit AD.
- Decodes address-phase and data-phase strobes from the bus master.
- Holds an 8-register BCD time/date file that advances on a 1 Hz tick.
- Serves as the on-chip RTC model for bench/loopback builds; drives AD only during valid read phases.

Parameters:
SYNC_STAGES, 2, synchronizer depth on cs_n/rd_n/wr_n/a_d/ad_in (minimum 2)
RESET_HOUR, 8'h00, BCD reset value of the hours register

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cs_n  input  1  chip select, active low
rd_n  input  1  read strobe, active low
wr_n  input  1  write strobe, active low (also strobes address)
a_d  input  1  0 = address phase, 1 = data phase
ad_in  input  8  AD bus as seen at the pins
ad_out  output  8  read data to AD bus
ad_oe  output  1  AD bus output enable (1 = responder drives)
tick_1hz  input  1  one-clk pulse, advances time
err  output  1  sticky error flag (mirror of status bit0)

Behaviour:
- Reset (async): ad_out=8'h00, ad_oe=0, err=0, addr latch=8'h00, FSM=IDLE; regs 0x00/0x01=8'h00, 0x02=RESET_HOUR, 0x03=8'h01, 0x04=8'h01, 0x05=8'h00, 0x06=8'h00, 0x07=8'h00; tick_pending=0.
- Synchronization: all five bus inputs pass through SYNC_STAGES flops; decode uses synced values (_s) and one extra delayed copy (_d).
- Register map:
  - 0x00 sec, 0x01 min, 0x02 hour (BCD, 24 h).
  - 0x03 day, 0x04 month, 0x05 year (BCD, plain storage, no calendar carry).
  - 0x06 control (bit0 = halt).
  - 0x07 status (bit0 = sticky error; write 1 clears, other bits read 0).
- FSM states: IDLE, ADDR, WDATA, RDATA.
  - IDLE->ADDR: cs_s=0, wr_s=0, a_d_s=0.
  - IDLE->WDATA: cs_s=0, wr_s=0, a_d_s=1.
  - IDLE->RDATA: cs_s=0, rd_s=0, a_d_s=1.
- End of ADDR: wr_s rises while cs_d=0 (cs may rise in the same cycle as wr). Latch ad_in_d into addr; return to IDLE.
- End of WDATA: same edge condition. Write ad_in_d to reg[addr]; return to IDLE.
- Early cs deassert: cs_s rising with wr_s still 0 aborts ADDR/WDATA without a latch or write; return to IDLE.
- RDATA entry cycle: snapshot reg[addr] into ad_out and assert ad_oe on the next clk. Latency from pin rd_n fall to ad_oe=1 is SYNC_STAGES+1 clk.
- RDATA hold: ad_out stays stable for the whole phase, even if a tick occurs. ad_oe deasserts the cycle after rd_s=1 or cs_s=1; go to IDLE. ad_out keeps its last value.
- Address > 0x07:
  - Write: ignored, sets err.
  - Read: returns 8'h00, sets err.
- a_d_s toggling while in ADDR/WDATA/RDATA: treated as protocol error. Set err, abort to IDLE, ad_oe=0.
- Time advance: tick_1hz (or tick_pending) with halt=0:
  - sec+1 BCD; 0x59->0x00 carries to min.
  - min 0x59->0x00 carries to hour.
  - hour 0x23->0x00.
  - With halt=1, ticks are dropped.
- Write/tick collision: a data write and a tick in the same cycle apply the write; tick_pending is set and the tick is applied the following cycle.
- Non-BCD values written to time regs are stored as-is. Increment follows binary+1 until the low nibble reaches 9 logic; no correction.
- Reset mid-cycle: all state returns to reset values immediately, ad_oe=0 asynchronously.

Test Plan:
- Write addr 0x01, data 0x45 (address phase 10 clk, data phase 8 clk) -> reg 0x01=0x45; subsequent read of 0x01 gives ad_out=0x45, ad_oe=1 from SYNC_STAGES+1 clk after rd_n fall to 1 clk after rd_n rise (synced).
- Preload sec=0x59, min=0x59, hour=0x23, one tick_1hz -> sec=0x00, min=0x00, hour=0x00; day unchanged.
- Write 0x06=0x01, pulse tick 3 times, read 0x00 -> unchanged. Write 0x06=0x00, one tick -> sec+1.
- Read addr 0x10 -> ad_out=0x00, err=1. Write 0x07=0x01 -> err=0.
- Data write to 0x00 (0x30) coincident with tick_1hz -> sec=0x31 one clk after the write cycle.
- Assert reset during RDATA with ad_oe=1 -> ad_oe=0 same cycle, regs at reset values, FSM IDLE.

Source files
------------

// File: rtl/rtc_bus_responder_if.sv
// Multiplexed address/data RTC bus: strobes, phase select and split AD lanes.
interface rtc_bus_responder_if;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;

    modport master (
        output cs_n, rd_n, wr_n, a_d, ad_in,
        input  ad_out, ad_oe
    );

    modport slave (
        input  cs_n, rd_n, wr_n, a_d, ad_in,
        output ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_responder.sv
// RTC bus responder: synchronizes the multiplexed bus, decodes address/data
// phases and serves an 8-entry BCD time/date register file advanced by a 1 Hz tick.
module rtc_bus_responder #(
    parameter int unsigned SYNC_STAGES = 2,      // must be >= 2
    parameter logic [7:0]  RESET_HOUR  = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    rtc_bus_responder_if.slave    bus_io,
    input  logic                  tick_1hz,
    output logic                  err
);

    typedef enum logic [1:0] {StIdle, StAddr, StWdata, StRdata} state_e;

    // Idle bus: strobes high, address phase, AD zero.
    localparam logic [11:0] SyncRst = 12'hE00;

    logic [11:0] bus_in;
    logic [11:0] sync_q [SYNC_STAGES];
    logic [10:0] dly_q;

    logic       cs_s, rd_s, wr_s, a_d_s;
    logic       cs_d, wr_d, a_d_d;
    logic [7:0] ad_in_d;

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       ad_oe_q, ad_oe_d;
    logic       err_q, err_d;
    logic       tick_pending_q, tick_pending_d;
    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hour_q, hour_d;
    logic [7:0] day_q, day_d;
    logic [7:0] month_q, month_d;
    logic [7:0] year_q, year_d;
    logic       halt_q, halt_d;

    logic       wr_en;
    logic       wr_rise;
    logic       cs_rise;
    logic       ad_toggle;
    logic       addr_valid;
    logic       tick_req;
    logic [7:0] rd_val;

    assign bus_in = {bus_io.cs_n, bus_io.rd_n, bus_io.wr_n, bus_io.a_d, bus_io.ad_in};

    assign {cs_s, rd_s, wr_s, a_d_s} = sync_q[SYNC_STAGES-1][11:8];
    assign {cs_d, wr_d, a_d_d}       = dly_q[10:8];
    assign ad_in_d                   = dly_q[7:0];

    // Phase ends on wr rising while cs was still low a cycle earlier; cs may rise with wr.
    assign wr_rise    = wr_s & ~wr_d & ~cs_d;
    assign cs_rise    = cs_s & ~cs_d;
    assign ad_toggle  = a_d_s ^ a_d_d;
    assign addr_valid = (addr_q[7:3] == 5'd0);
    assign tick_req   = tick_1hz | tick_pending_q;

    assign bus_io.ad_out = ad_out_q;
    assign bus_io.ad_oe  = ad_oe_q;
    assign err           = err_q;

    // Increment with decimal carry out of the low nibble only; non-BCD input is not corrected.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'h9) begin
            return {v[7:4] + 4'h1, 4'h0};
        end
        return v + 8'h01;
    endfunction

    // Input synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SyncRst;
            end
            dly_q <= {3'b110, 8'h00};
        end else begin
            sync_q[0] <= bus_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dly_q <= {cs_s, wr_s, a_d_s, sync_q[SYNC_STAGES-1][7:0]};
        end
    end

    // Register read mux; unmapped addresses read as zero.
    always_comb begin
        rd_val = 8'h00;
        case (addr_q)
            8'h00:   rd_val = sec_q;
            8'h01:   rd_val = min_q;
            8'h02:   rd_val = hour_q;
            8'h03:   rd_val = day_q;
            8'h04:   rd_val = month_q;
            8'h05:   rd_val = year_q;
            8'h06:   rd_val = {7'b0, halt_q};
            8'h07:   rd_val = {7'b0, err_q};
            default: rd_val = 8'h00;
        endcase
    end

    // Bus phase FSM: next state, address latch, read drive and error flag.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        ad_out_d = ad_out_q;
        ad_oe_d  = ad_oe_q;
        err_d    = err_q;
        wr_en    = 1'b0;
        case (state_q)
            StIdle: begin
                if (!cs_s && !wr_s) begin
                    state_d = a_d_s ? StWdata : StAddr;
                end else if (!cs_s && !rd_s && a_d_s) begin
                    // Snapshot here so data is held for the whole read phase.
                    state_d  = StRdata;
                    ad_out_d = rd_val;
                    ad_oe_d  = 1'b1;
                    if (!addr_valid) begin
                        err_d = 1'b1;
                    end
                end
            end
            StAddr: begin
                if (wr_rise) begin
                    addr_d  = ad_in_d;
                    state_d = StIdle;
                end else if (ad_toggle) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (cs_rise) begin
                    state_d = StIdle;
                end
            end
            StWdata: begin
                if (wr_rise) begin
                    wr_en   = 1'b1;
                    state_d = StIdle;
                    if (!addr_valid) begin
                        err_d = 1'b1;
                    end else if (addr_q == 8'h07 && ad_in_d[0]) begin
                        err_d = 1'b0;
                    end
                end else if (ad_toggle) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (cs_rise) begin
                    state_d = StIdle;
                end
            end
            StRdata: begin
                if (ad_toggle) begin
                    err_d   = 1'b1;
                    ad_oe_d = 1'b0;
                    state_d = StIdle;
                end else if (rd_s || cs_s) begin
                    ad_oe_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                ad_oe_d = 1'b0;
            end
        endcase
    end

    // Register file update: bus writes win, a colliding tick is deferred one cycle.
    always_comb begin
        sec_d          = sec_q;
        min_d          = min_q;
        hour_d         = hour_q;
        day_d          = day_q;
        month_d        = month_q;
        year_d         = year_q;
        halt_d         = halt_q;
        tick_pending_d = 1'b0;
        if (wr_en) begin
            tick_pending_d = tick_req;
            if (addr_valid) begin
                case (addr_q[2:0])
                    3'd0: sec_d   = ad_in_d;
                    3'd1: min_d   = ad_in_d;
                    3'd2: hour_d  = ad_in_d;
                    3'd3: day_d   = ad_in_d;
                    3'd4: month_d = ad_in_d;
                    3'd5: year_d  = ad_in_d;
                    3'd6: halt_d  = ad_in_d[0];
                    3'd7: ;  // status clear handled with err
                    default: ;
                endcase
            end
        end else if (tick_req && !halt_q) begin
            if (sec_q == 8'h59) begin
                sec_d = 8'h00;
                if (min_q == 8'h59) begin
                    min_d  = 8'h00;
                    hour_d = (hour_q == 8'h23) ? 8'h00 : bcd_inc(hour_q);
                end else begin
                    min_d = bcd_inc(min_q);
                end
            end else begin
                sec_d = bcd_inc(sec_q);
            end
        end
    end

    // State and register file flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            addr_q         <= 8'h00;
            ad_out_q       <= 8'h00;
            ad_oe_q        <= 1'b0;
            err_q          <= 1'b0;
            tick_pending_q <= 1'b0;
            sec_q          <= 8'h00;
            min_q          <= 8'h00;
            hour_q         <= RESET_HOUR;
            day_q          <= 8'h01;
            month_q        <= 8'h01;
            year_q         <= 8'h00;
            halt_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            ad_out_q       <= ad_out_d;
            ad_oe_q        <= ad_oe_d;
            err_q          <= err_d;
            tick_pending_q <= tick_pending_d;
            sec_q          <= sec_d;
            min_q          <= min_d;
            hour_q         <= hour_d;
            day_q          <= day_d;
            month_q        <= month_d;
            year_q         <= year_d;
            halt_q         <= halt_d;
        end
    end

endmodule
